// File: rtl/alu_seq.sv
// alu_seq: single-command sequencer with a small register file. It drives an external
// combinational ALU, writes the result back and returns a flagged response.
module alu_seq #(
   parameter int REG_AW = 2,
   parameter int DW     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [4:0]        cmd_op,
   input  logic [REG_AW-1:0] cmd_dst,
   input  logic [REG_AW-1:0] cmd_src_a,
   input  logic [REG_AW-1:0] cmd_src_b,
   input  logic              cmd_imm_sel,
   input  logic [DW-1:0]     cmd_imm,
   output logic [DW-1:0]     alu_a,
   output logic [DW-1:0]     alu_b,
   output logic [4:0]        alu_op,
   input  logic [DW-1:0]     alu_out,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_data,
   output logic              rsp_zero,
   output logic              rsp_ovf,
   output logic              rsp_err,
   input  logic [REG_AW-1:0] dbg_sel,
   output logic [DW-1:0]     dbg_data
);

   localparam int NREG = 2 ** REG_AW;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_LOAD = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_NOR  = 5'h06;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DW-1:0]     regs_q [NREG];
   logic [DW-1:0]     regs_d [NREG];
   logic [DW-1:0]     alu_a_q, alu_a_d;
   logic [DW-1:0]     alu_b_q, alu_b_d;
   logic [4:0]        alu_op_q, alu_op_d;
   logic [REG_AW-1:0] dst_q, dst_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]     rsp_data_q, rsp_data_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic              rsp_ovf_q, rsp_ovf_d;
   logic              rsp_err_q, rsp_err_d;

   logic              accept;
   logic              alu_cmd;
   logic [DW-1:0]     opnd_b;
   logic              ovf_exec;

   assign accept  = cmd_valid && (state_q == IDLE);
   assign alu_cmd = (cmd_op >= OP_ADD) && (cmd_op <= OP_NOR);
   assign opnd_b  = cmd_imm_sel ? cmd_imm : regs_q[cmd_src_b];

   // Signed overflow judged on the operands actually presented to the ALU this cycle.
   always_comb begin
      ovf_exec = 1'b0;
      if (alu_op_q == OP_ADD)
         ovf_exec = (alu_a_q[DW-1] == alu_b_q[DW-1]) && (alu_out[DW-1] != alu_a_q[DW-1]);
      else if (alu_op_q == OP_SUB)
         ovf_exec = (alu_a_q[DW-1] != alu_b_q[DW-1]) && (alu_out[DW-1] != alu_a_q[DW-1]);
   end

   // State register and all datapath flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         // NOTE: the register file is built from plain flops, so it is cleared here like any other state.
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= OP_NOP;
         dst_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_ovf_q   <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples pre-edge values together.
         state_q     <= state_d;
         regs_q      <= regs_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         dst_q       <= dst_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_zero_q  <= rsp_zero_d;
         rsp_ovf_q   <= rsp_ovf_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = alu_cmd ? EXEC : WB;
         EXEC:    state_d = WB;
         WB:      if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next values; LOAD and illegal ops complete their writeback on the accept edge.
   always_comb begin
      // NOTE: every _d defaults to its _q so no branch leaves a signal unassigned (no latches).
      regs_d      = regs_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      dst_d       = dst_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_zero_d  = rsp_zero_q;
      rsp_ovf_d   = rsp_ovf_q;
      rsp_err_d   = rsp_err_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d = regs_q[cmd_src_a];
               alu_b_d = opnd_b;
               dst_d   = cmd_dst;
               if (alu_cmd) begin
                  alu_op_d = cmd_op;
               end else if (cmd_op == OP_LOAD) begin
                  regs_d[cmd_dst] = opnd_b;
                  rsp_valid_d     = 1'b1;
                  rsp_data_d      = opnd_b;
                  rsp_zero_d      = (opnd_b == '0);
                  rsp_ovf_d       = 1'b0;
                  rsp_err_d       = 1'b0;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
                  rsp_zero_d  = 1'b0;
                  rsp_ovf_d   = 1'b0;
                  rsp_err_d   = 1'b1;
               end
            end
         end
         EXEC: begin
            regs_d[dst_q] = alu_out;
            alu_op_d      = OP_NOP;
            rsp_valid_d   = 1'b1;
            rsp_data_d    = alu_out;
            rsp_zero_d    = (alu_out == '0);
            rsp_ovf_d     = ovf_exec;
            rsp_err_d     = 1'b0;
         end
         WB: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: begin
            alu_op_d    = OP_NOP;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      cmd_ready = (state_q == IDLE);
      dbg_data  = regs_q[dbg_sel];
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed bench for alu_seq with a behavioural ALU on the alu_* port;
// expected values are hand-computed constants.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [4:0]  cmd_op;
   logic [1:0]  cmd_dst, cmd_src_a, cmd_src_b;
   logic        cmd_imm_sel;
   logic [15:0] cmd_imm;
   logic [15:0] alu_a, alu_b, alu_out;
   logic [4:0]  alu_op;
   logic        rsp_valid, rsp_ready, rsp_zero, rsp_ovf, rsp_err;
   logic [15:0] rsp_data;
   logic [1:0]  dbg_sel;
   logic [15:0] dbg_data;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [4:0]  op;
      logic [1:0]  dst;
      logic [1:0]  sa;
      logic [1:0]  sb;
      logic        isel;
      logic [15:0] imm;
      logic [15:0] data;
      logic        z;
      logic        v;
   } vec_t;

   vec_t vecs [10];

   alu_seq #(.REG_AW(2), .DW(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
      .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   // Stand-in for the lab ALU instance.
   always_comb begin
      case (alu_op)
         5'd1:    alu_out = alu_a + alu_b;
         5'd2:    alu_out = alu_a - alu_b;
         5'd3:    alu_out = alu_a & alu_b;
         5'd4:    alu_out = alu_a | alu_b;
         5'd5:    alu_out = alu_a ^ alu_b;
         5'd6:    alu_out = ~(alu_a | alu_b);
         default: alu_out = 16'h0000;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Presents one command and returns #1 after the accept edge; waits counts cycles spent waiting for cmd_ready.
   task automatic issue(input logic [4:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sb, input logic isel, input logic [15:0] imm,
                        output int waits);
      waits       = 0;
      cmd_op      = op;
      cmd_dst     = dst;
      cmd_src_a   = sa;
      cmd_src_b   = sb;
      cmd_imm_sel = isel;
      cmd_imm     = imm;
      cmd_valid   = 1'b1;
      while (!cmd_ready && waits < 20) begin
         @(posedge clk); #1;
         waits++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   // Called right after issue(); lat = 1 means rsp_valid seen in the cycle after accept.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({cmd_ready, rsp_valid, rsp_zero, rsp_ovf, rsp_err} !== 5'b10000)
         $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, rsp_valid, rsp_zero, rsp_ovf, rsp_err});
      else pass_cnt++;
      total_cnt++;
      if ({alu_a, alu_b, alu_op, rsp_data} !== 53'h0)
         $display("FAIL reset_data: alu_a=%h alu_b=%h alu_op=%h rsp_data=%h want all 0", alu_a, alu_b, alu_op, rsp_data);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         dbg_sel = 2'(i);
         #1;
         total_cnt++;
         if (dbg_data !== 16'h0000) $display("FAIL reset_reg%0d: got %h want 0000", i, dbg_data);
         else pass_cnt++;
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_load();
      int w;
      issue(5'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h7FFF, w);
      dbg_sel = 2'd0;
      #1;
      total_cnt++;
      if ({rsp_valid, rsp_zero, rsp_ovf, rsp_err, cmd_ready} !== 5'b10000)
         $display("FAIL load_flags: got %b want 10000", {rsp_valid, rsp_zero, rsp_ovf, rsp_err, cmd_ready});
      else pass_cnt++;
      total_cnt++;
      if (rsp_data !== 16'h7FFF) $display("FAIL load_data: got %h want 7fff", rsp_data);
      else pass_cnt++;
      total_cnt++;
      if (dbg_data !== 16'h7FFF) $display("FAIL load_dbg: got %h want 7fff", dbg_data);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if ({rsp_valid, cmd_ready} !== 2'b01)
         $display("FAIL load_handshake: valid/ready got %b want 01", {rsp_valid, cmd_ready});
      else pass_cnt++;
   endtask

   task automatic test_add_ovf();
      int w;
      total_cnt++;
      if (alu_op !== 5'd0) $display("FAIL add_op_idle: got %h want 00", alu_op);
      else pass_cnt++;
      issue(5'd1, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0001, w);
      total_cnt++;
      if ({alu_op, rsp_valid, alu_a, alu_b} !== {5'd1, 1'b0, 16'h7FFF, 16'h0001})
         $display("FAIL add_exec: op=%h valid=%b a=%h b=%h want 01 0 7fff 0001", alu_op, rsp_valid, alu_a, alu_b);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if ({alu_op, rsp_valid, rsp_zero, rsp_ovf, rsp_err} !== {5'd0, 4'b1010})
         $display("FAIL add_wb_flags: op=%h v/z/o/e=%b want 00 1010", alu_op, {rsp_valid, rsp_zero, rsp_ovf, rsp_err});
      else pass_cnt++;
      total_cnt++;
      if (rsp_data !== 16'h8000) $display("FAIL add_data: got %h want 8000", rsp_data);
      else pass_cnt++;
      @(posedge clk); #1;
      dbg_sel = 2'd1;
      #1;
      total_cnt++;
      if ({alu_op, rsp_valid, dbg_data} !== {5'd0, 1'b0, 16'h8000})
         $display("FAIL add_after: op=%h valid=%b r1=%h want 00 0 8000", alu_op, rsp_valid, dbg_data);
      else pass_cnt++;
   endtask

   task automatic test_alu_ops();
      int w, lat;
      // r0 = 7FFF, r1 = 8000 on entry; vector 1 sets r3 = 7FFF for later use.
      vecs = '{
         '{5'd2, 2'd2, 2'd0, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0},
         '{5'd5, 2'd3, 2'd1, 2'd0, 1'b1, 16'hFFFF, 16'h7FFF, 1'b0, 1'b0},
         '{5'd3, 2'd2, 2'd1, 2'd0, 1'b1, 16'hF0F0, 16'h8000, 1'b0, 1'b0},
         '{5'd4, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b0},
         '{5'd6, 2'd2, 2'd0, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0},
         '{5'd2, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0001, 16'h7FFF, 1'b0, 1'b1},
         '{5'd1, 2'd2, 2'd3, 2'd3, 1'b0, 16'h0000, 16'hFFFE, 1'b0, 1'b1},
         '{5'd1, 2'd2, 2'd1, 2'd1, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1},
         '{5'd2, 2'd2, 2'd0, 2'd0, 1'b1, 16'hFFFF, 16'h8000, 1'b0, 1'b1},
         '{5'd1, 2'd2, 2'd0, 2'd0, 1'b1, 16'h8001, 16'h0000, 1'b1, 1'b0}
      };
      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].isel, vecs[i].imm, w);
         wait_rsp(lat);
         total_cnt++;
         if (lat != 2) $display("FAIL ops%0d_latency: got %0d want 2", i, lat);
         else pass_cnt++;
         total_cnt++;
         if (rsp_data !== vecs[i].data) $display("FAIL ops%0d_data: got %h want %h", i, rsp_data, vecs[i].data);
         else pass_cnt++;
         total_cnt++;
         if ({rsp_zero, rsp_ovf, rsp_err} !== {vecs[i].z, vecs[i].v, 1'b0})
            $display("FAIL ops%0d_flags: z/o/e got %b want %b", i, {rsp_zero, rsp_ovf, rsp_err}, {vecs[i].z, vecs[i].v, 1'b0});
         else pass_cnt++;
         @(posedge clk); #1;
         dbg_sel = vecs[i].dst;
         #1;
         total_cnt++;
         if (dbg_data !== vecs[i].data) $display("FAIL ops%0d_writeback: got %h want %h", i, dbg_data, vecs[i].data);
         else pass_cnt++;
      end
   endtask

   task automatic test_illegal_hold();
      int w;
      rsp_ready = 1'b0;
      issue(5'h09, 2'd0, 2'd1, 2'd1, 1'b1, 16'h1234, w);
      // A command presented while busy must be ignored.
      cmd_op = 5'd0; cmd_dst = 2'd0; cmd_imm_sel = 1'b1; cmd_imm = 16'h1234; cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if ({rsp_valid, rsp_err, rsp_zero, rsp_ovf, cmd_ready, rsp_data} !== {5'b11000, 16'h0000})
            $display("FAIL illegal_hold%0d: v/e/z/o/rdy=%b data=%h want 11000 0000", i,
                     {rsp_valid, rsp_err, rsp_zero, rsp_ovf, cmd_ready}, rsp_data);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      dbg_sel = 2'd0;
      #1;
      total_cnt++;
      if ({rsp_valid, cmd_ready} !== 2'b01)
         $display("FAIL illegal_release: valid/ready got %b want 01", {rsp_valid, cmd_ready});
      else pass_cnt++;
      total_cnt++;
      if (dbg_data !== 16'h7FFF) $display("FAIL illegal_r0: got %h want 7fff", dbg_data);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int w, lat;
      issue(5'd0, 2'd0, 2'd0, 2'd0, 1'b1, 16'h0005, w);
      total_cnt++;
      if ({rsp_valid, cmd_ready, rsp_data} !== {2'b10, 16'h0005})
         $display("FAIL b2b_load: valid/ready=%b data=%h want 10 0005", {rsp_valid, cmd_ready}, rsp_data);
      else pass_cnt++;
      issue(5'd1, 2'd0, 2'd0, 2'd0, 1'b0, 16'h0000, w);
      total_cnt++;
      if (w != 1) $display("FAIL b2b_accept_gap: waited %0d cycles want 1", w);
      else pass_cnt++;
      total_cnt++;
      if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_exec: got %b want 0", cmd_ready);
      else pass_cnt++;
      wait_rsp(lat);
      total_cnt++;
      if ({lat == 2, cmd_ready, rsp_data} !== {2'b10, 16'h000A})
         $display("FAIL b2b_add: lat=%0d ready=%b data=%h want 2 0 000a", lat, cmd_ready, rsp_data);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if ({rsp_valid, cmd_ready} !== 2'b01)
         $display("FAIL b2b_release: valid/ready got %b want 01", {rsp_valid, cmd_ready});
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_exec();
      int w;
      logic seen;
      issue(5'd1, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0003, w);
      total_cnt++;
      if (alu_op !== 5'd1) $display("FAIL rstmid_exec: alu_op got %h want 01", alu_op);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if ({alu_op, cmd_ready, rsp_valid} !== {5'd0, 2'b10})
         $display("FAIL rstmid_async: op=%h ready=%b valid=%b want 00 1 0", alu_op, cmd_ready, rsp_valid);
      else pass_cnt++;
      @(posedge clk); #1;
      rst  = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) seen = 1'b1;
         @(posedge clk); #1;
      end
      total_cnt++;
      if ({seen, cmd_ready} !== 2'b01) $display("FAIL rstmid_rsp: seen/ready got %b want 01", {seen, cmd_ready});
      else pass_cnt++;
      dbg_sel = 2'd1;
      #1;
      total_cnt++;
      if (dbg_data !== 16'h0000) $display("FAIL rstmid_r1: got %h want 0000", dbg_data);
      else pass_cnt++;
   endtask

   initial begin
      rst         = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = 5'd0;
      cmd_dst     = 2'd0;
      cmd_src_a   = 2'd0;
      cmd_src_b   = 2'd0;
      cmd_imm_sel = 1'b0;
      cmd_imm     = 16'h0000;
      rsp_ready   = 1'b1;
      dbg_sel     = 2'd0;
      test_reset();
      test_load();
      test_add_ovf();
      test_alu_ops();
      test_illegal_hold();
      test_back_to_back();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
